// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with frame-based debounce.
//
// A clock divider produces a one-clk scan tick every CLK_DIV cycles. One row
// is driven low at a time; each tick samples the columns of the driven row
// and advances to the next row. After row 3 is sampled, the four row samples
// form one frame whose result is NONE, a single key code, or MULTI. A frame
// result must repeat for DEBOUNCE_FRAMES consecutive frames before it is
// accepted onto the outputs.
//
// Build option: define KEYPAD_GHOST_REJECT_EN to treat a MULTI frame as NONE.
// Without it, MULTI resolves to the lowest key code seen in the frame.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   col_in     [3:0] column inputs, active-low (pulled up externally)
//   row_out    [3:0] row drive, one-hot active-low
//   key_vaild  high while a debounced key is held
//   key_code   [3:0] debounced key code (4*row + col), valid while key_vaild=1
//   key_press  one-clk pulse on each newly accepted key
module keypad_scan #(
    parameter int CLK_DIV         = 50000,
    parameter int DEBOUNCE_FRAMES = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic       key_vaild,
    output logic [3:0] key_code,
    output logic       key_press
);

`ifdef KEYPAD_GHOST_REJECT_EN
    localparam bit GHOST_REJECT = 1'b1;
`else
    localparam bit GHOST_REJECT = 1'b0;
`endif

    localparam int             DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]     DEB_TARGET = 4'(DEBOUNCE_FRAMES);

    // Scan divider and row index
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       row_q, row_d;
    logic             tick;

    // Frame accumulator: key seen, more than one key seen, first (lowest) code
    logic       acc_seen_q, acc_seen_d;
    logic       acc_multi_q, acc_multi_d;
    logic [3:0] acc_code_q, acc_code_d;

    // Completed frame result {hit, code}; NONE is encoded as all zeros
    logic       frame_done_q, frame_done_d;
    logic [4:0] frame_res_q, frame_res_d;

    // Debounce state
    logic [4:0] prev_q, prev_d;
    logic [3:0] cnt_q, cnt_d;

    logic       key_vaild_q, key_vaild_d;
    logic [3:0] key_code_q, key_code_d;
    logic       key_press_q, key_press_d;

    // Per-row sample decode
    logic [3:0] row_keys;
    logic       row_hit;
    logic       row_multi;
    logic [1:0] row_col;
    logic       seen_n, multi_n, hit_n;
    logic [3:0] code_n;

    always_comb begin
        row_keys  = ~col_in;
        row_hit   = |row_keys;
        // Two or more bits set: clearing the lowest set bit leaves something
        row_multi = |(row_keys & (row_keys - 4'd1));
        row_col   = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (row_keys[c]) row_col = 2'(c);
        end

        // Rows are scanned in ascending order, so the first key seen in a
        // frame is always the lowest code.
        seen_n  = acc_seen_q | row_hit;
        multi_n = acc_multi_q | row_multi | (acc_seen_q & row_hit);
        code_n  = acc_seen_q ? acc_code_q : {row_q, row_col};
        hit_n   = seen_n & ~(GHOST_REJECT & multi_n);
    end

    always_comb begin
        tick         = (div_q == DIV_MAX);
        div_d        = tick ? '0 : div_q + 1'b1;
        row_d        = row_q;
        acc_seen_d   = acc_seen_q;
        acc_multi_d  = acc_multi_q;
        acc_code_d   = acc_code_q;
        frame_done_d = 1'b0;
        frame_res_d  = frame_res_q;

        if (tick) begin
            row_d = row_q + 2'd1;
            if (row_q == 2'd3) begin
                frame_done_d = 1'b1;
                frame_res_d  = hit_n ? {1'b1, code_n} : 5'd0;
                acc_seen_d   = 1'b0;
                acc_multi_d  = 1'b0;
                acc_code_d   = 4'd0;
            end else begin
                acc_seen_d  = seen_n;
                acc_multi_d = multi_n;
                acc_code_d  = code_n;
            end
        end
    end

    // Debounce and acceptance, one clk after the frame completes
    always_comb begin
        prev_d      = prev_q;
        cnt_d       = cnt_q;
        key_vaild_d = key_vaild_q;
        key_code_d  = key_code_q;
        key_press_d = 1'b0;

        if (frame_done_q) begin
            prev_d = frame_res_q;
            if (frame_res_q == prev_q) begin
                cnt_d = (cnt_q == 4'd15) ? 4'd15 : cnt_q + 4'd1;
            end else begin
                cnt_d = 4'd1;
            end

            if (cnt_d == DEB_TARGET) begin
                if (frame_res_q[4]) begin
                    key_vaild_d = 1'b1;
                    key_code_d  = frame_res_q[3:0];
                    // Re-acceptance of the held code must not pulse again
                    key_press_d = !key_vaild_q || (frame_res_q[3:0] != key_code_q);
                end else begin
                    key_vaild_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q        <= '0;
            row_q        <= 2'd0;
            acc_seen_q   <= 1'b0;
            acc_multi_q  <= 1'b0;
            acc_code_q   <= 4'd0;
            frame_done_q <= 1'b0;
            frame_res_q  <= 5'd0;
            prev_q       <= 5'd0;
            cnt_q        <= 4'd0;
            key_vaild_q  <= 1'b0;
            key_code_q   <= 4'd0;
            key_press_q  <= 1'b0;
        end else begin
            div_q        <= div_d;
            row_q        <= row_d;
            acc_seen_q   <= acc_seen_d;
            acc_multi_q  <= acc_multi_d;
            acc_code_q   <= acc_code_d;
            frame_done_q <= frame_done_d;
            frame_res_q  <= frame_res_d;
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            key_vaild_q  <= key_vaild_d;
            key_code_q   <= key_code_d;
            key_press_q  <= key_press_d;
        end
    end

    always_comb begin
        row_out   = ~(4'b0001 << row_q);
        key_vaild = key_vaild_q;
        key_code  = key_code_q;
        key_press = key_press_q;
    end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed self-checking bench for keypad_scan with
// CLK_DIV=4, DEBOUNCE_FRAMES=3. A 16-clk frame follows each reset release;
// cyc counts rising edges since release (edge 0 = first edge with reset=0),
// so frame f completes at edge 16f+15 and is accepted at edge 16f+16.
// A key matrix model drives col_in from the row currently pulled low.
module tb_keypad_scan;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic        key_vaild;
    logic [3:0]  key_code;
    logic        key_press;

    logic [15:0] keys = 16'h0000;
    int          cyc = -1;
    int          press_count = 0;
    int          press_base = 0;
    int          vectors = 0;
    int          miscompares = 0;

`ifdef KEYPAD_GHOST_REJECT_EN
    localparam bit GHOST = 1'b1;
`else
    localparam bit GHOST = 1'b0;
`endif

    keypad_scan #(
        .CLK_DIV         (4),
        .DEBOUNCE_FRAMES (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .col_in    (col_in),
        .row_out   (row_out),
        .key_vaild (key_vaild),
        .key_code  (key_code),
        .key_press (key_press)
    );

    always #5 clk = ~clk;

    // Pressed key at row r, column c pulls col c low while row r is driven
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (row_out[r] === 1'b0) col_in = col_in & ~keys[4*r +: 4];
        end
    end

    always @(posedge clk) begin
        if (reset) cyc <= -1;
        else       cyc <= cyc + 1;
        if (key_press === 1'b1) press_count <= press_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after edge e (bounded)
    task automatic goto(input int e);
        int guard;
        guard = 0;
        while (cyc < e && guard < 5000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("goto", cyc, e);
    endtask

    initial begin
        // Reset held for 10 clk
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("rst_row", {28'd0, row_out}, 32'he);
            check("rst_vaild", {31'd0, key_vaild}, 32'd0);
            check("rst_press", {31'd0, key_press}, 32'd0);
        end
        check("rst_code", {28'd0, key_code}, 32'd0);
        reset = 1'b0;

        // Press key 9 (row 2, col 1) from the start of frame 0
        goto(0);
        keys = 16'h0200;
        goto(2);  check("row0", {28'd0, row_out}, 32'he);
        goto(3);  check("row1", {28'd0, row_out}, 32'hd);
        goto(7);  check("row2", {28'd0, row_out}, 32'hb);
        goto(11); check("row3", {28'd0, row_out}, 32'h7);
        goto(15); check("row_wrap", {28'd0, row_out}, 32'he);
        goto(47);
        check("k9_pre_vaild", {31'd0, key_vaild}, 32'd0);
        check("k9_pre_presses", press_count, 32'd0);
        goto(48);
        check("k9_vaild", {31'd0, key_vaild}, 32'd1);
        check("k9_code", {28'd0, key_code}, 32'd9);
        check("k9_press", {31'd0, key_press}, 32'd1);
        goto(49);
        check("k9_press_end", {31'd0, key_press}, 32'd0);

        // Release at frame 5; NONE accepted after frames 5..7
        goto(80);
        check("k9_one_pulse", press_count, 32'd1);
        keys = 16'h0000;
        goto(127); check("rel_pre_vaild", {31'd0, key_vaild}, 32'd1);
        goto(128);
        check("rel_vaild", {31'd0, key_vaild}, 32'd0);
        check("rel_code_held", {28'd0, key_code}, 32'd9);
        check("rel_press", {31'd0, key_press}, 32'd0);

        // Bounce: key 9 on/off/on/off over frames 8..11, then held
        keys = 16'h0200;
        goto(144); keys = 16'h0000;
        goto(160); keys = 16'h0200;
        goto(176); keys = 16'h0000;
        check("bnc_mid_vaild", {31'd0, key_vaild}, 32'd0);
        goto(192); keys = 16'h0200;
        goto(239);
        check("bnc_pre_vaild", {31'd0, key_vaild}, 32'd0);
        check("bnc_pre_presses", press_count, 32'd1);
        goto(240);
        check("bnc_vaild", {31'd0, key_vaild}, 32'd1);
        check("bnc_code", {28'd0, key_code}, 32'd9);
        check("bnc_press", {31'd0, key_press}, 32'd1);
        goto(241);
        check("bnc_presses", press_count, 32'd2);

        // Keys 5 and 13 together from frame 16
        goto(256);
        keys = 16'h2020;
        goto(303);
        check("multi_pre_vaild", {31'd0, key_vaild}, 32'd1);
        check("multi_pre_code", {28'd0, key_code}, 32'd9);
        goto(304);
        check("multi_vaild", {31'd0, key_vaild}, GHOST ? 32'd0 : 32'd1);
        check("multi_code", {28'd0, key_code}, GHOST ? 32'd9 : 32'd5);
        check("multi_press", {31'd0, key_press}, GHOST ? 32'd0 : 32'd1);

        // Long hold through counter saturation: no further pulses
        goto(613);
        check("sat_vaild", {31'd0, key_vaild}, GHOST ? 32'd0 : 32'd1);
        check("sat_code", {28'd0, key_code}, GHOST ? 32'd9 : 32'd5);
        check("sat_presses", press_count, GHOST ? 32'd2 : 32'd3);

        // Reset mid-frame (row 1 driven) while keys are still held
        goto(614);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("mid_rst_row", {28'd0, row_out}, 32'he);
            check("mid_rst_vaild", {31'd0, key_vaild}, 32'd0);
            check("mid_rst_code", {28'd0, key_code}, 32'd0);
            check("mid_rst_press", {31'd0, key_press}, 32'd0);
        end
        reset = 1'b0;
        press_base = press_count;
        goto(0);
        check("rerel_row", {28'd0, row_out}, 32'he);
        goto(47);
        check("rerel_pre_vaild", {31'd0, key_vaild}, 32'd0);
        goto(48);
        check("rerel_vaild", {31'd0, key_vaild}, GHOST ? 32'd0 : 32'd1);
        check("rerel_code", {28'd0, key_code}, GHOST ? 32'd0 : 32'd5);
        goto(60);
        check("rerel_presses", press_count - press_base, GHOST ? 32'd0 : 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000, meaning clk cycles per scan tick (1 kHz at 50 MHz).
REQ-002 SHALL have parameter DEBOUNCE_FRAMES, default 5, meaning consecutive identical frames required to accept a new result (legal range 1..15).
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, a synchronous, active-high reset.
REQ-005 SHALL have port col_in, input, 4, matrix columns, active-low, externally pulled up.
REQ-006 SHALL have port row_out, output, 4, matrix row drive, one-hot active-low.
REQ-007 SHALL have port key_vaild, output, 1, high while a debounced key is held.
REQ-008 SHALL have port key_code, output, 4, the debounced key code, meaningful only while key_vaild=1.
REQ-009 SHALL have port key_press, output, 1, a one-clk pulse on each newly accepted key.

Function
REQ-010 SHALL generate tick, a one-clk pulse: counter 0..CLK_DIV-1, tick when counter==CLK_DIV-1, then wrap to 0.
REQ-011 SHALL drive row r (0..3) low, one row at a time; on each tick it SHALL sample col_in for the driven row, then advance r (3 wraps to 0) in the same cycle.
REQ-012 SHALL decode a pressed key at row r, column c (col_in[c]=0) as code 4*r+c.
REQ-013 SHALL form a frame after the tick that samples row 3, with result NONE, a single code, or MULTI when more than one key is seen in the frame.
REQ-014 SHALL, in the default build, resolve MULTI to the lowest code seen.
REQ-015 SHALL use a 4-bit candidate counter: a frame result equal to the previous frame's result increments it (saturating at 15), and a differing result resets it to 1.
REQ-016 SHALL accept the candidate when the counter reaches DEBOUNCE_FRAMES, in the clk cycle after frame completion.
- Candidate NONE: key_vaild <= 0.
- Candidate a code: key_vaild <= 1 and key_code <= that code.
REQ-017 SHALL hold key_vaild and key_code unchanged between acceptances, including while an unstable candidate is bouncing.
REQ-018 SHALL pulse key_press for exactly one clk when an acceptance sets key_vaild from 0 to 1, or changes key_code while key_vaild stays 1.
REQ-019 SHALL NOT pulse key_press again when the same code is re-accepted after counter saturation.
REQ-020 SHALL make the worst-case press-to-key_vaild latency 4*DEBOUNCE_FRAMES+4 ticks plus 2 clk.

Reset
REQ-021 SHALL, while reset=1, set the divider, row index, frame accumulator and candidate counter to 0, and set the previous result to NONE.
REQ-022 SHALL hold outputs during reset at row_out=4'b1110, key_vaild=0, key_code=0, key_press=0.
REQ-023 SHALL, after reset is released mid-frame, discard the partial frame and start scanning at row 0.

Configuration
REQ-024 SHALL, when macro KEYPAD_GHOST_REJECT_EN is defined, treat a MULTI frame as NONE, so pressing two keys releases any held key after debounce.
REQ-025 SHALL, when KEYPAD_GHOST_REJECT_EN is undefined, apply REQ-014.

Verification (CLK_DIV=4, DEBOUNCE_FRAMES=3)
REQ-026 SHALL cover: reset held 10 clk -> row_out=1110, key_vaild=0, key_press=0 throughout.
REQ-027 SHALL cover: hold row2/col1 -> key_vaild=1 with key_code=9 after 3 stable frames, and exactly one key_press pulse.
REQ-028 SHALL cover: key 9 bounces (toggles every frame for 4 frames) then holds -> no output change until 3 stable frames, then accepted.
REQ-029 SHALL cover: release after key_vaild=1 -> key_vaild=0 after 3 NONE frames; key_code is held and there is no pulse.
REQ-030 SHALL cover: keys 5 and 13 pressed together -> default build key_code=5; with KEYPAD_GHOST_REJECT_EN, key_vaild stays 0.
REQ-031 SHALL cover: reset asserted mid-frame during a press -> outputs cleared, and the press is re-accepted only after a full 3-frame debounce.
